ultrasonic_ranger: RTL and testbench

Sensor-side producer of the 5-bit `distance` bus consumed by the Tarea1 motor/excess/7-segment logic. It periodically fires an ultrasonic trigger pulse and measures the echo pulse width. It converts the width to distance units and presents a registered `distance` with a one-cycle `valid` strobe. Echo timeout and overrange saturate the result at 31.

---
 rtl/ultrasonic_ranger_pkg.sv | 22 ++
 rtl/ultrasonic_ranger_if.sv | 31 +++
 rtl/ultrasonic_ranger_echo_sync.sv | 38 +++
 rtl/ultrasonic_ranger.sv | 157 +++++++++++++++
 tb/tb_ultrasonic_ranger.sv | 216 +++++++++++++++++++++
 5 files changed

// File: rtl/ultrasonic_ranger_pkg.sv
// Shared types and constants for the ultrasonic ranger: FSM state encoding
// and the width/saturation value of the distance bus.
package ranger_pkg;

    localparam int DIST_W = 5;
    localparam logic [DIST_W-1:0] DIST_MAX = 5'd31;

    // One extra bit so a count of 32 is representable and overrange is detectable.
    localparam int UNIT_W = DIST_W + 1;

    // Cycles from a change on the raw echo pin to its appearance on echo_s.
    localparam int SYNC_LAT = 2;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        HOLDOFF
    } ranger_state_t;

endpackage

// File: rtl/ultrasonic_ranger_if.sv
// Sensor-side bundle: enable/echo in, trigger and distance result out.
// The slave modport is the ranger itself; master is whoever consumes it.
interface ultrasonic_ranger_if;
    import ranger_pkg::*;

    logic              enable;
    logic              echo;
    logic              trig;
    logic [DIST_W-1:0] distance;
    logic              valid;
    logic              timeout;

    modport master (
        output enable,
        output echo,
        input  trig,
        input  distance,
        input  valid,
        input  timeout
    );

    modport slave (
        input  enable,
        input  echo,
        output trig,
        output distance,
        output valid,
        output timeout
    );

endinterface

// File: rtl/ultrasonic_ranger_echo_sync.sv
// Two-flop synchronizer for an asynchronous level input, with single-cycle
// rise/fall pulses derived from the synchronized level.
module echo_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic rise,
    output logic fall
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;

    always_comb begin
        meta_d = async_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_out = sync_q;
    assign rise     = sync_q & ~prev_q;
    assign fall     = ~sync_q & prev_q;

endmodule

// File: rtl/ultrasonic_ranger.sv
// Periodic ultrasonic ranging: fires a trigger, times the echo pulse and
// reports a saturated 5-bit distance with a one-cycle valid strobe.
module ultrasonic_ranger
    import ranger_pkg::*;
#(
    parameter int TRIG_CYCLES    = 10,
    parameter int TICKS_PER_UNIT = 58,
    parameter int WAIT_TIMEOUT   = 2000,
    parameter int MEAS_PERIOD    = 60000
) (
    input  logic                clk,
    input  logic                rst,
    ultrasonic_ranger_if.slave  bus
);

    // The wait window includes the synchronizer delay so an echo that rises
    // on the pin within WAIT_TIMEOUT cycles of trigger end is still caught.
    localparam int WAIT_WIN = WAIT_TIMEOUT + SYNC_LAT;
    localparam int CNT_MAX  = (TRIG_CYCLES > WAIT_WIN) ? TRIG_CYCLES : WAIT_WIN;
    localparam int CNT_W    = $clog2(CNT_MAX + 1);
    localparam int TICK_W   = $clog2(TICKS_PER_UNIT);
    localparam int PER_W    = $clog2(MEAS_PERIOD);

    localparam logic [CNT_W-1:0]  TRIG_LAST = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0]  WAIT_LAST = CNT_W'(WAIT_WIN - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICKS_PER_UNIT - 1);
    localparam logic [PER_W-1:0]  PER_LAST  = PER_W'(MEAS_PERIOD - 1);
    localparam logic [UNIT_W-1:0] UNIT_SAT  = {1'b0, DIST_MAX};

    logic echo_s, echo_rise, echo_fall;

    echo_sync u_echo_sync (
        .clk      (clk),
        .rst      (rst),
        .async_in (bus.echo),
        .sync_out (echo_s),
        .rise     (echo_rise),
        .fall     (echo_fall)
    );

    ranger_state_t     state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [TICK_W-1:0] tick_q, tick_d;
    logic [UNIT_W-1:0] unit_q, unit_d;
    logic [PER_W-1:0]  period_q, period_d;
    logic [DIST_W-1:0] distance_q, distance_d;
    logic              timeout_q, timeout_d;
    logic              valid_q, valid_d;
    logic [UNIT_W-1:0] unit_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            tick_q     <= '0;
            unit_q     <= '0;
            period_q   <= '0;
            distance_q <= '0;
            timeout_q  <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            tick_q     <= tick_d;
            unit_q     <= unit_d;
            period_q   <= period_d;
            distance_q <= distance_d;
            timeout_q  <= timeout_d;
            valid_q    <= valid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        tick_d     = tick_q;
        unit_d     = unit_q;
        distance_d = distance_q;
        timeout_d  = timeout_q;
        valid_d    = 1'b0;
        unit_nxt   = unit_q + 1'b1;
        // Saturate rather than wrap so a stuck echo still sees the period end.
        period_d   = (period_q == PER_LAST) ? period_q : period_q + 1'b1;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (bus.enable && !echo_s) state_d = TRIG;
            end

            TRIG: begin
                if (cnt_q == TRIG_LAST) begin
                    cnt_d   = '0;
                    state_d = WAIT_ECHO;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            WAIT_ECHO: begin
                if (echo_rise) begin
                    tick_d  = TICK_W'(1);
                    unit_d  = '0;
                    state_d = MEASURE;
                end else if (cnt_q == WAIT_LAST) begin
                    distance_d = DIST_MAX;
                    timeout_d  = 1'b1;
                    valid_d    = 1'b1;
                    state_d    = HOLDOFF;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            MEASURE: begin
                if (echo_fall) begin
                    distance_d = (unit_q > UNIT_SAT) ? DIST_MAX : unit_q[DIST_W-1:0];
                    timeout_d  = 1'b0;
                    valid_d    = 1'b1;
                    state_d    = HOLDOFF;
                end else if (echo_s) begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (unit_nxt > UNIT_SAT) begin
                            distance_d = DIST_MAX;
                            timeout_d  = 1'b1;
                            valid_d    = 1'b1;
                            state_d    = HOLDOFF;
                        end else begin
                            unit_d = unit_nxt;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
            end

            HOLDOFF: begin
                cnt_d = '0;
                if (period_q == PER_LAST) begin
                    if (!bus.enable)  state_d = IDLE;
                    else if (!echo_s) state_d = TRIG;
                end
            end

            default: state_d = IDLE;
        endcase

        if (state_d == TRIG && state_q != TRIG) period_d = '0;
    end

    assign bus.trig     = (state_q == TRIG);
    assign bus.distance = distance_q;
    assign bus.valid    = valid_q;
    assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Scoreboard bench for ultrasonic_ranger: expected {distance,timeout} is
// queued when an echo is scheduled and checked when valid strobes.
module tb_ultrasonic_ranger;
    import ranger_pkg::*;

    localparam int TRIG_C = 2;
    localparam int TPU    = 4;
    localparam int WTO    = 16;
    localparam int PER    = 200;
    localparam int BUDGET = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ultrasonic_ranger_if bus ();

    ultrasonic_ranger #(
        .TRIG_CYCLES    (TRIG_C),
        .TICKS_PER_UNIT (TPU),
        .WAIT_TIMEOUT   (WTO),
        .MEAS_PERIOD    (PER)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk = 0;
    int n_err = 0;
    int rise_cnt = 0;
    int vld_cnt = 0;
    logic [5:0] sb[$];

    task automatic chk(input string tag, input int got, input int exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0d exp=%0d at cycle %0d", tag, got, exp, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_rise(output int at);
        int n = 0;
        do begin @(negedge clk); n++; end while (!bus.trig && n < BUDGET);
        chk("trig_rise_seen", int'(bus.trig), 1);
        at = cyc;
    endtask

    task automatic wait_fall(output int at);
        int n = 0;
        do begin @(negedge clk); n++; end while (bus.trig && n < BUDGET);
        chk("trig_fall_seen", int'(bus.trig), 0);
        at = cyc;
    endtask

    task automatic wait_valid(output int at);
        int n = 0;
        do begin @(negedge clk); n++; end while (!bus.valid && n < BUDGET);
        chk("valid_seen", int'(bus.valid), 1);
        at = cyc;
    endtask

    task automatic monitor();
        logic tp = 1'b0;
        logic vp = 1'b0;
        int tw = 0;
        logic [5:0] e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.valid) begin
                    vld_cnt++;
                    chk("valid_pulse", int'(vp), 0);
                    if (sb.size() == 0) begin
                        chk("sb_underflow", sb.size(), 1);
                    end else begin
                        e = sb.pop_front();
                        chk("distance", int'(bus.distance), int'(e[5:1]));
                        chk("timeout", int'(bus.timeout), int'(e[0]));
                    end
                end
                if (bus.trig && !tp) rise_cnt++;
                if (bus.trig) tw++;
                else if (tp) begin
                    chk("trig_width", tw, TRIG_C);
                    tw = 0;
                end
            end
            tp = bus.trig;
            vp = bus.valid;
        end
    endtask

    // Echo goes high dly cycles after trig falls and stays high hi cycles.
    task automatic after_rise(input int dly, input int hi, input int exp_d, input bit drop_en);
        int f, vc;
        wait_fall(f);
        sb.push_back({5'(exp_d), 1'b0});
        step(dly);
        bus.echo = 1'b1;
        if (drop_en) begin
            step(hi / 2);
            bus.enable = 1'b0;
            step(hi - hi / 2);
        end else begin
            step(hi);
        end
        bus.echo = 1'b0;
        wait_valid(vc);
    endtask

    task automatic measure(input int dly, input int hi, input int exp_d, input bit drop_en,
                           output int rise_at);
        wait_rise(rise_at);
        after_rise(dly, hi, exp_d, drop_en);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int r1, r2, f, vc, k, rc, vc0;
        bus.enable = 1'b0;
        bus.echo   = 1'b0;
        fork
            monitor();
        join_none

        step(3);
        chk("rst_trig", int'(bus.trig), 0);
        chk("rst_distance", int'(bus.distance), 0);
        chk("rst_valid", int'(bus.valid), 0);
        chk("rst_timeout", int'(bus.timeout), 0);
        rst = 1'b0;
        step(2);
        bus.enable = 1'b1;

        // basic, floor and zero-width
        measure(5, 40, 10, 1'b0, r1);
        measure(3, 3, 0, 1'b0, r1);
        measure(3, 7, 1, 1'b0, r1);

        // no echo: timeout result, then the next trigger one period later
        wait_rise(r1);
        wait_fall(f);
        sb.push_back({DIST_MAX, 1'b1});
        wait_valid(vc);
        chk("noecho_latency", vc - f, 18);
        measure(4, 8, 2, 1'b0, r2);
        chk("noecho_period", r2 - r1, PER);

        // overrange with a stuck echo
        wait_rise(r1);
        wait_fall(f);
        sb.push_back({DIST_MAX, 1'b1});
        step(3);
        bus.echo = 1'b1;
        k = cyc;
        wait_valid(vc);
        chk("ovr_latency", vc - k, 130);
        rc = rise_cnt;
        step(k + 200 - cyc);
        bus.echo = 1'b0;
        chk("stuck_no_retrig", rise_cnt - rc, 0);
        wait_rise(r1);
        chk("retrig_latency", r1 - (k + 200), 3);
        after_rise(5, 40, 10, 1'b0);
        measure(5, 20, 5, 1'b0, r2);
        chk("period", r2 - r1, PER);

        // enable dropped mid-measure: result reported, then parked
        measure(5, 20, 5, 1'b1, r1);
        rc = rise_cnt;
        step(3 * PER);
        chk("parked_no_trig", rise_cnt - rc, 0);
        chk("parked_trig", int'(bus.trig), 0);

        // async reset in the middle of a measurement
        bus.enable = 1'b1;
        wait_rise(r1);
        wait_fall(f);
        step(3);
        bus.echo = 1'b1;
        step(10);
        #1 rst = 1'b1;
        #1;
        chk("arst_trig", int'(bus.trig), 0);
        chk("arst_valid", int'(bus.valid), 0);
        chk("arst_distance", int'(bus.distance), 0);
        chk("arst_timeout", int'(bus.timeout), 0);
        vc0 = vld_cnt;
        bus.echo = 1'b0;
        step(3);
        rst = 1'b0;
        measure(5, 12, 3, 1'b0, r2);
        chk("arst_single_valid", vld_cnt - vc0, 1);

        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
